cam_wr_packer: RTL and testbench

Packs the camera pixel stream into 256-bit DDR words and issues one write request per word to the DDR request arbiter. It sits directly upstream of the arbiter's camera write port: it drives `camera_wr_req`, `camera_wr_address` and `camera_wr_data`, and obeys the arbiter's `busy` back-pressure. A 2-entry word buffer absorbs short busy periods. Each frame lands in one of several exposure buffers for the HDR merge.

---
 rtl/cam_wr_packer_if.sv | 26 ++
 rtl/cam_wr_packer.sv | 199 +++++++++++++++++++
 tb/tb_cam_wr_packer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_wr_packer_if.sv
// cam_wr_packer_if: write-request bus between the camera packer and the DDR
// request arbiter's camera write port.
//   camera_wr_req      1-cycle write request (packer -> arbiter)
//   camera_wr_address  25-bit word address, valid with req
//   camera_wr_data     256-bit word data, valid with req
//   busy               arbiter back-pressure (arbiter -> packer)
interface cam_wr_packer_if;
  logic         camera_wr_req;
  logic [24:0]  camera_wr_address;
  logic [255:0] camera_wr_data;
  logic         busy;

  modport master (
    output camera_wr_req,
    output camera_wr_address,
    output camera_wr_data,
    input  busy
  );

  modport slave (
    input  camera_wr_req,
    input  camera_wr_address,
    input  camera_wr_data,
    output busy
  );
endinterface

// File: rtl/cam_wr_packer.sv
// cam_wr_packer: packs the camera pixel stream into 256-bit DDR words and
// issues one write request per word through a 2-entry word buffer.
//
// Ports:
//   clk_133M, rst_n_133M   clock, synchronous active-low reset
//   init_done              DDR ready; frames starting while low are ignored
//   frame_start/frame_end  frame delimiters (1-cycle pulses)
//   pix_valid, pix_data    pixel strobe and value
//   exposure_sel           exposure buffer index, latched at frame_start
//   wr_bus                 write-request bus (req/address/data out, busy in)
//   frame_done             pulse when the last word of a frame has issued
//   overflow               sticky word-drop flag, cleared by frame_start
//   drop_cnt, frame_cnt    statistics counters
//
// Build option: define CAM_WR_PACKER_STATS_EN to make drop_cnt/frame_cnt
// live; otherwise both are tied to zero.
//
// state  | meaning
// IDLE   | waiting for frame_start with init_done
// ACTIVE | packing pixels into words
// FLUSH  | one cycle: push the partial word if any pixels are pending
// DRAIN  | waiting for the word buffer to empty; frame_done on exit
module cam_wr_packer #(
  parameter int          PIX_W        = 16,
  parameter int          ADDR_STEP    = 16,
  parameter logic [24:0] FRAME_STRIDE = 25'h0040000,
  parameter logic [24:0] BASE_ADDR    = 25'h0000000
) (
  input  logic               clk_133M,
  input  logic               rst_n_133M,
  input  logic               init_done,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic [1:0]         exposure_sel,
  cam_wr_packer_if.master    wr_bus,
  output logic               frame_done,
  output logic               overflow,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        frame_cnt
);

  localparam int WORD_W   = 256;
  localparam int WORD_PIX = WORD_W / PIX_W;
  localparam int IDX_W    = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_PIX - 1);
  localparam logic [24:0]      STEP     = 25'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]  pix_idx;
  logic [WORD_W-1:0] acc, acc_ins, push_data;
  logic [24:0]       word_addr;

  logic [24:0]       fifo_addr [2];
  logic [WORD_W-1:0] fifo_data [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_cnt;

  logic              req, req_q;
  logic [24:0]       last_addr;
  logic [WORD_W-1:0] last_data;

  logic start_ok, word_done, push_req, push_ok, fifo_full, drop;

  assign start_ok = (state == IDLE) && frame_start && init_done;

  // Current word with the incoming pixel dropped into its lane.
  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < WORD_PIX; k++) begin
      if (pix_idx == IDX_W'(k)) acc_ins[k*PIX_W +: PIX_W] = pix_data;
    end
  end

  assign word_done = (state == ACTIVE) && pix_valid && (pix_idx == LAST_IDX);
  assign push_req  = word_done || ((state == FLUSH) && (pix_idx != '0));
  // Lanes above the last pixel are already zero because acc clears per word.
  assign push_data = word_done ? acc_ins : acc;

  // Issue needs an idle cycle after every request; pop shares the req cycle,
  // so a push into a full buffer in that same cycle still fits.
  assign fifo_full = (fifo_cnt == 2'd2);
  assign req       = (fifo_cnt != 2'd0) && !wr_bus.busy && !req_q;
  assign push_ok   = push_req && (!fifo_full || req);
  assign drop      = push_req && fifo_full && !req;

  assign wr_bus.camera_wr_req     = req;
  assign wr_bus.camera_wr_address = req ? fifo_addr[rd_ptr] : last_addr;
  assign wr_bus.camera_wr_data    = req ? fifo_data[rd_ptr] : last_data;

  always_ff @(posedge clk_133M) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= word_addr;
      fifo_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      req_q     <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      req_q <= req;
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (req) begin
        rd_ptr    <= ~rd_ptr;
        last_addr <= fifo_addr[rd_ptr];
        last_data <= fifo_data[rd_ptr];
      end
      case ({push_ok, req})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Packing datapath. The word address advances on every completed word,
  // dropped or not, so later words keep their place in the frame buffer.
  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      pix_idx   <= '0;
      acc       <= '0;
      word_addr <= '0;
      overflow  <= 1'b0;
    end else begin
      if (start_ok) begin
        word_addr <= BASE_ADDR + FRAME_STRIDE * 25'(exposure_sel);
        pix_idx   <= '0;
        acc       <= '0;
        overflow  <= 1'b0;
      end else if ((state == ACTIVE) && pix_valid) begin
        if (word_done) begin
          pix_idx   <= '0;
          acc       <= '0;
          word_addr <= word_addr + STEP;
        end else begin
          pix_idx <= pix_idx + IDX_W'(1);
          acc     <= acc_ins;
        end
      end else if (state == FLUSH) begin
        pix_idx <= '0;
        acc     <= '0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (start_ok) state_nxt = ACTIVE;
      ACTIVE: if (frame_end) state_nxt = FLUSH;
      FLUSH:  state_nxt = DRAIN;
      DRAIN: begin
        // An empty buffer also means no request can be in flight.
        if (fifo_cnt == 2'd0) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CAM_WR_PACKER_STATS_EN
  logic [15:0] drop_q, frame_q;

  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      drop_q  <= '0;
      frame_q <= '0;
    end else begin
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (frame_done) frame_q <= frame_q + 16'd1;
    end
  end

  assign drop_cnt  = drop_q;
  assign frame_cnt = frame_q;
`else
  assign drop_cnt  = '0;
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_wr_packer.sv
module tb_cam_wr_packer;

  localparam int          STEP   = 16;
  localparam logic [24:0] STRIDE = 25'h0040000;
  localparam logic [24:0] BASE   = 25'h0000000;
`ifdef CAM_WR_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst_n, init_done, frame_start, frame_end, pix_valid;
  logic [15:0] pix_data;
  logic [1:0]  exposure_sel;
  logic        frame_done, overflow;
  logic [15:0] drop_cnt, frame_cnt;

  cam_wr_packer_if wr_if ();

  cam_wr_packer dut (
    .clk_133M     (clk),
    .rst_n_133M   (rst_n),
    .init_done    (init_done),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .exposure_sel (exposure_sel),
    .wr_bus       (wr_if),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .frame_cnt    (frame_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [24:0]  a;
    logic [255:0] d;
  } ent_t;

  ent_t         mq[$];          // words waiting to issue, in order
  logic [15:0]  fp[$];          // every accepted pixel of the current frame
  int           m_phase;        // 0 idle, 1 receiving, 2 flush cycle, 3 draining
  int           m_words;        // words completed this frame (dropped included)
  logic [24:0]  m_base;
  bit           m_prev_req, m_ovf;
  int           m_drop, m_frames;
  logic [24:0]  m_last_a;
  logic [255:0] m_last_d;
  bit           checking = 1'b0;

  logic [24:0]  obs_a[$];
  logic [255:0] obs_d[$];
  int           done_cnt = 0;

  function automatic logic [255:0] word_of_frame(int n);
    logic [255:0] w = '0;
    for (int j = 0; j < 16; j++)
      if (16*n + j < fp.size()) w[j*16 +: 16] = fp[16*n + j];
    return w;
  endfunction

  function automatic logic [255:0] ramp_word(int lo, int lanes);
    logic [255:0] w = '0;
    for (int j = 0; j < lanes; j++) w[j*16 +: 16] = 16'(lo + j);
    return w;
  endfunction

  always @(negedge clk) begin
    bit   e_req, e_done, completed;
    ent_t e;
    e_req  = (mq.size() > 0) && !wr_if.busy && !m_prev_req;
    e_done = (m_phase == 3) && (mq.size() == 0);
    if (wr_if.camera_wr_req === 1'b1) begin
      obs_a.push_back(wr_if.camera_wr_address);
      obs_d.push_back(wr_if.camera_wr_data);
    end
    if (frame_done === 1'b1) done_cnt++;
    if (checking) begin
      check("req", 256'(wr_if.camera_wr_req), 256'(e_req));
      check("addr", 256'(wr_if.camera_wr_address), 256'(e_req ? mq[0].a : m_last_a));
      check("data", wr_if.camera_wr_data, e_req ? mq[0].d : m_last_d);
      check("frame_done", 256'(frame_done), 256'(e_done));
      check("overflow", 256'(overflow), 256'(m_ovf));
      check("drop_cnt", 256'(drop_cnt), STATS ? 256'(m_drop) : 256'(0));
      check("frame_cnt", 256'(frame_cnt), STATS ? 256'(m_frames) : 256'(0));
    end
    if (!rst_n) begin
      mq.delete(); fp.delete();
      m_phase = 0; m_words = 0; m_base = '0; m_prev_req = 0; m_ovf = 0;
      m_drop = 0; m_frames = 0; m_last_a = '0; m_last_d = '0;
    end else begin
      if (e_req) begin
        m_last_a = mq[0].a;
        m_last_d = mq[0].d;
        void'(mq.pop_front());
      end
      completed = 0;
      if (m_phase == 1 && pix_valid) begin
        fp.push_back(pix_data);
        if (fp.size() % 16 == 0) completed = 1;
      end else if (m_phase == 2 && (fp.size() % 16) != 0) begin
        completed = 1;
      end
      if (completed) begin
        e.a = 25'(m_base + m_words * STEP);
        e.d = word_of_frame(m_words);
        m_words++;
        if (mq.size() < 2) mq.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      case (m_phase)
        0: if (frame_start && init_done) begin
             m_phase = 1;
             m_base  = 25'(BASE + STRIDE * exposure_sel);
             fp.delete();
             m_words = 0;
             m_ovf   = 0;
           end
        1: if (frame_end) m_phase = 2;
        2: m_phase = 3;
        default: if (e_done) begin
             m_phase  = 0;
             m_frames = (m_frames + 1) % 65536;
           end
      endcase
      m_prev_req = e_req;
    end
  end

  // ---------------- stimulus ----------------
  int busy_mode = 0;  // 0 low, 1 high, 2 toggle, 3 ~25% high, 4 ~80% high

  initial begin
    wr_if.busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (busy_mode)
        0: wr_if.busy = 1'b0;
        1: wr_if.busy = 1'b1;
        2: wr_if.busy = ~wr_if.busy;
        3: wr_if.busy = ($urandom_range(0, 3) == 0);
        default: wr_if.busy = ($urandom_range(0, 9) < 8);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int sel, input int npix, input bit rnd, input bit gaps,
                            input int release_at);
    frame_start = 1; exposure_sel = 2'(sel); tick(); frame_start = 0;
    for (int i = 0; i < npix; i++) begin
      if (i == release_at) busy_mode = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_valid    = 0;
        frame_start  = ($urandom_range(0, 7) == 0);
        exposure_sel = 2'($urandom_range(0, 3));
        tick();
        frame_start = 0;
      end
      pix_valid = 1;
      pix_data  = rnd ? 16'($urandom) : 16'(i);
      tick();
    end
    pix_valid = 0; frame_end = 1; tick(); frame_end = 0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 600; k++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check("frame_done_pulses", 256'(done_cnt - d0), 256'(1));
  endtask

  task automatic check_zero(input string p);
    check({p, "_req"},   256'(wr_if.camera_wr_req), 256'(0));
    check({p, "_addr"},  256'(wr_if.camera_wr_address), 256'(0));
    check({p, "_data"},  wr_if.camera_wr_data, 256'(0));
    check({p, "_done"},  256'(frame_done), 256'(0));
    check({p, "_ovf"},   256'(overflow), 256'(0));
    check({p, "_drop"},  256'(drop_cnt), 256'(0));
    check({p, "_fcnt"},  256'(frame_cnt), 256'(0));
  endtask

  typedef struct {
    int          sel, npix, bmode, rel, reqs;
    logic [24:0] a_first, a_last;
    int          drops;
    bit          ovf;
    int          lo, lanes;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int d0, exp_drop_tot, exp_frm_tot, sel, np, bsel;
    bit ok_start;
    //         sel npix bmode rel reqs first        last         drops ovf lo lanes
    tbl[0] = '{2, 32, 0, -1, 2, 25'h0080000, 25'h0080010, 0, 0, 16, 16};
    tbl[1] = '{0, 20, 0, -1, 2, 25'h0000000, 25'h0000010, 0, 0, 16, 4};
    tbl[2] = '{1, 16, 0, -1, 1, 25'h0040000, 25'h0040000, 0, 0, 0, 16};
    tbl[3] = '{3, 0,  0, -1, 0, 25'h00C0000, 25'h00C0000, 0, 0, 0, 0};
    tbl[4] = '{0, 64, 1, 48, 3, 25'h0000000, 25'h0000030, 1, 1, 48, 16};
    tbl[5] = '{1, 64, 2, -1, 4, 25'h0040000, 25'h0040030, 0, 0, 48, 16};
    tbl[6] = '{2, 37, 0, -1, 3, 25'h0080000, 25'h0080020, 0, 0, 32, 5};

    rst_n = 0; init_done = 1; frame_start = 0; frame_end = 0;
    pix_valid = 0; pix_data = '0; exposure_sel = '0;
    repeat (3) tick();
    check_zero("reset");
    checking = 1;
    rst_n = 1;
    tick();

    exp_drop_tot = 0; exp_frm_tot = 0;
    for (int t = 0; t < 7; t++) begin
      obs_a.delete(); obs_d.delete();
      d0 = done_cnt;
      busy_mode = tbl[t].bmode; tick();
      send_frame(tbl[t].sel, tbl[t].npix, 0, 0, tbl[t].rel);
      wait_done(d0);
      busy_mode = 0;
      exp_drop_tot += tbl[t].drops;
      exp_frm_tot++;
      check($sformatf("t%0d_nreq", t), 256'(obs_a.size()), 256'(tbl[t].reqs));
      if (tbl[t].reqs > 0 && obs_a.size() > 0) begin
        check($sformatf("t%0d_first_addr", t), 256'(obs_a[0]), 256'(tbl[t].a_first));
        check($sformatf("t%0d_last_addr", t), 256'(obs_a[$]), 256'(tbl[t].a_last));
        check($sformatf("t%0d_last_data", t), obs_d[$], ramp_word(tbl[t].lo, tbl[t].lanes));
      end
      check($sformatf("t%0d_overflow", t), 256'(overflow), 256'(tbl[t].ovf));
      check($sformatf("t%0d_drop_cnt", t), 256'(drop_cnt), STATS ? 256'(exp_drop_tot) : 256'(0));
      check($sformatf("t%0d_frame_cnt", t), 256'(frame_cnt), STATS ? 256'(exp_frm_tot) : 256'(0));
      tick();
    end

    // frame_start while DDR not ready is ignored
    init_done = 0; obs_a.delete(); d0 = done_cnt;
    send_frame(1, 16, 1, 0, -1);
    repeat (5) tick();
    check("initlow_nreq", 256'(obs_a.size()), 256'(0));
    check("initlow_done", 256'(done_cnt - d0), 256'(0));
    init_done = 1;

    // second frame_start mid-frame neither relatches the buffer nor restarts
    obs_a.delete(); d0 = done_cnt;
    frame_start = 1; exposure_sel = 1; tick(); frame_start = 0;
    for (int i = 0; i < 10; i++) begin pix_valid = 1; pix_data = 16'(i); tick(); end
    pix_valid = 0; frame_start = 1; exposure_sel = 3; tick(); frame_start = 0;
    for (int i = 10; i < 16; i++) begin pix_valid = 1; pix_data = 16'(i); tick(); end
    pix_valid = 0; frame_end = 1; tick(); frame_end = 0;
    wait_done(d0);
    check("midstart_nreq", 256'(obs_a.size()), 256'(1));
    if (obs_a.size() > 0) check("midstart_addr", 256'(obs_a[0]), 256'(25'h0040000));

    // reset mid-word
    frame_start = 1; exposure_sel = 1; tick(); frame_start = 0;
    for (int i = 0; i < 8; i++) begin pix_valid = 1; pix_data = 16'(100 + i); tick(); end
    pix_valid = 0; rst_n = 0; tick();
    check_zero("rst_word");
    rst_n = 1; obs_a.delete();
    for (int i = 0; i < 16; i++) begin pix_valid = 1; pix_data = 16'(i); tick(); end
    pix_valid = 0; frame_end = 1; tick(); frame_end = 0;
    repeat (5) tick();
    check("rst_word_noreq", 256'(obs_a.size()), 256'(0));

    // reset while draining two held words
    busy_mode = 1; tick();
    send_frame(0, 32, 1, 0, -1);
    repeat (2) tick();
    rst_n = 0; tick();
    check_zero("rst_drain");
    rst_n = 1; busy_mode = 0; obs_a.delete();
    repeat (10) tick();
    check("rst_drain_noreq", 256'(obs_a.size()), 256'(0));

    // randomized frames against the model
    for (int r = 0; r < 40; r++) begin
      sel  = $urandom_range(0, 3);
      np   = $urandom_range(0, 70);
      bsel = $urandom_range(0, 9);
      busy_mode = (bsel < 2) ? 4 : ((bsel < 6) ? 3 : 0);
      init_done = ($urandom_range(0, 9) != 0);
      ok_start  = init_done;
      d0 = done_cnt;
      send_frame(sel, np, 1, 1, -1);
      if (ok_start) wait_done(d0);
      else repeat (4) tick();
      busy_mode = 0; init_done = 1;
      repeat (2) tick();
    end

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
